// File: rtl/iwrr_round_tracker.sv
// Credit and round manager for the interleaved weighted round-robin arbiter.
// Holds one remaining-weight credit per requester, consumes credit on grants,
// reloads all credits atomically at round boundaries and counts rounds.
module iwrr_round_tracker #(
   parameter int unsigned P_REQUESTER_NUM = 3,
   parameter int unsigned P_WEIGHT_W      = 2,
   parameter int unsigned P_ROUND_CNT_W   = 8,
   parameter int unsigned P_MODE          = 0
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0]     req_weight_i,
   input  logic [P_REQUESTER_NUM-1:0]                req_i,
   input  logic                                      grant_vld_i,
   input  logic [P_REQUESTER_NUM-1:0]                grant_i,
   output logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0]     credit_o,
   output logic [P_REQUESTER_NUM-1:0]                eligible_o,
   output logic                                      round_comp_o,
   output logic [P_ROUND_CNT_W-1:0]                  round_cnt_o,
   output logic                                      err_o
);

   localparam int unsigned N  = P_REQUESTER_NUM;
   localparam int unsigned W  = P_WEIGHT_W;
   localparam int unsigned CW = P_ROUND_CNT_W;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [N*W-1:0]  credit_q, credit_d;
   logic [N-1:0]    eligible_q, eligible_d;
   logic            grant_seen_q, grant_seen_d;
   logic            round_comp_q, round_comp_d;
   logic [CW-1:0]   round_cnt_q, round_cnt_d;
   logic            err_q, err_d;

   logic            grant_onehot;
   logic            grant_ok;
   logic            hit_zero;
   logic [N*W-1:0]  credit_dec;
   logic            all_zero_cur;
   logic            all_zero_dec;
   logic            wc_idle;
   logic            complete;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Grant qualification, credit decrement, completion detect and next state
   always_comb begin
      state_d      = state_q;
      grant_onehot = 1'b0;
      grant_ok     = 1'b0;
      hit_zero     = 1'b0;
      credit_dec   = credit_q;
      all_zero_cur = 1'b1;
      all_zero_dec = 1'b1;
      wc_idle      = 1'b1;
      complete     = 1'b0;
      credit_d     = credit_q;
      eligible_d   = '0;
      grant_seen_d = grant_seen_q;
      round_comp_d = 1'b0;
      round_cnt_d  = round_cnt_q;
      err_d        = err_q;

      grant_onehot = (grant_i != '0) && ((grant_i & (grant_i - N'(1))) == '0);
      grant_ok     = (state_q == ST_RUN) && grant_vld_i && grant_onehot;

      for (int unsigned n = 0; n < N; n++) begin
         if (grant_ok && grant_i[n]) begin
            if (credit_q[n*W +: W] != '0) begin
               credit_dec[n*W +: W] = credit_q[n*W +: W] - W'(1);
            end else begin
               hit_zero = 1'b1;
            end
         end
         if (credit_q[n*W +: W] != '0) begin
            all_zero_cur = 1'b0;
         end
         if (credit_dec[n*W +: W] != '0) begin
            all_zero_dec = 1'b0;
            if (req_i[n]) begin
               wc_idle = 1'b0;
            end
         end
      end

      // Completion is judged on post-grant credits
      if (P_MODE == 0) begin
         complete = grant_ok && all_zero_dec;
      end else begin
         complete = (state_q == ST_RUN) && wc_idle && (grant_seen_q || grant_ok);
      end

      case (state_q)
         ST_INIT: begin
            credit_d     = req_weight_i;
            grant_seen_d = 1'b0;
            state_d      = ST_RUN;
            if (grant_vld_i) begin
               err_d = 1'b1;
            end
         end
         ST_RUN: begin
            credit_d     = credit_dec;
            grant_seen_d = grant_seen_q | grant_ok;
            if ((grant_vld_i && !grant_onehot) || hit_zero) begin
               err_d = 1'b1;
            end
            if (complete) begin
               credit_d     = req_weight_i;
               grant_seen_d = 1'b0;
               round_comp_d = 1'b1;
               round_cnt_d  = round_cnt_q + CW'(1);
            end else if (all_zero_cur && !grant_seen_q) begin
               // Idle with nothing to hand out: keep retrying the weights
               credit_d     = req_weight_i;
               grant_seen_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      for (int unsigned n = 0; n < N; n++) begin
         eligible_d[n] = (state_d == ST_RUN) && (credit_d[n*W +: W] != '0);
      end
   end

   // Credit, flag and counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         credit_q     <= '0;
         eligible_q   <= '0;
         grant_seen_q <= 1'b0;
         round_comp_q <= 1'b0;
         round_cnt_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         credit_q     <= credit_d;
         eligible_q   <= eligible_d;
         grant_seen_q <= grant_seen_d;
         round_comp_q <= round_comp_d;
         round_cnt_q  <= round_cnt_d;
         err_q        <= err_d;
      end
   end

   assign credit_o     = credit_q;
   assign eligible_o   = eligible_q;
   assign round_comp_o = round_comp_q;
   assign round_cnt_o  = round_cnt_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_iwrr_round_tracker.sv
// Self-checking bench: a STRICT instance (2-bit round counter) and a
// WORK_CONSERVING instance share stimulus; each is checked every cycle
// against a spec-level model, plus directed vectors and sequences.
module tb_iwrr_round_tracker;

   localparam int unsigned N = 3;
   localparam int unsigned W = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [5:0]   req_weight;
   logic [2:0]   req;
   logic         gv;
   logic [2:0]   grant;

   logic [5:0]   credit_s, credit_w;
   logic [2:0]   elig_s, elig_w;
   logic         comp_s, comp_w;
   logic [1:0]   cnt_s;
   logic [7:0]   cnt_w;
   logic         err_s, err_w;

   int total = 0;
   int bad   = 0;

   // Spec-level model state, index 0 = STRICT, 1 = WORK_CONSERVING
   int  m_cr   [2][3];
   bit  m_init [2];
   bit  m_seen [2];
   bit  m_comp [2];
   int  m_cnt  [2];
   bit  m_err  [2];
   int  m_mod  [2] = '{4, 256};

   always #5 clk = ~clk;

   iwrr_round_tracker #(
      .P_REQUESTER_NUM (3),
      .P_WEIGHT_W      (2),
      .P_ROUND_CNT_W   (2),
      .P_MODE          (0)
   ) u_strict (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_weight_i (req_weight),
      .req_i        (req),
      .grant_vld_i  (gv),
      .grant_i      (grant),
      .credit_o     (credit_s),
      .eligible_o   (elig_s),
      .round_comp_o (comp_s),
      .round_cnt_o  (cnt_s),
      .err_o        (err_s)
   );

   iwrr_round_tracker #(
      .P_REQUESTER_NUM (3),
      .P_WEIGHT_W      (2),
      .P_ROUND_CNT_W   (8),
      .P_MODE          (1)
   ) u_wc (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_weight_i (req_weight),
      .req_i        (req),
      .grant_vld_i  (gv),
      .grant_i      (grant),
      .credit_o     (credit_w),
      .eligible_o   (elig_w),
      .round_comp_o (comp_w),
      .round_cnt_o  (cnt_w),
      .err_o        (err_w)
   );

   function automatic int weight_of(input logic [5:0] w, input int n);
      logic [5:0] tmp;
      tmp = w >> (2 * n);
      return int'(tmp[1:0]);
   endfunction

   function automatic logic [5:0] pack_cr(input int m);
      logic [5:0] p;
      p = '0;
      for (int n = 0; n < 3; n++) p = p | (6'(m_cr[m][n] & 3) << (2 * n));
      return p;
   endfunction

   function automatic logic [2:0] model_elig(input int m);
      logic [2:0] e;
      e = '0;
      for (int n = 0; n < 3; n++) e[n] = !m_init[m] && (m_cr[m][n] != 0);
      return e;
   endfunction

   // One clock edge of the behaviour, written from the rules rather than the RTL
   task automatic model_step();
      int nxt [3];
      int ones, k, sum_cur, sum_nxt;
      bit valid, done, left;
      for (int m = 0; m < 2; m++) begin
         if (!rst_n) begin
            m_init[m] = 1; m_seen[m] = 0; m_comp[m] = 0; m_cnt[m] = 0; m_err[m] = 0;
            for (int n = 0; n < 3; n++) m_cr[m][n] = 0;
            continue;
         end
         m_comp[m] = 0;
         if (m_init[m]) begin
            for (int n = 0; n < 3; n++) m_cr[m][n] = weight_of(req_weight, n);
            m_init[m] = 0;
            m_seen[m] = 0;
            if (gv) m_err[m] = 1;
            continue;
         end
         ones  = $countones(grant);
         valid = gv && (ones == 1);
         if (gv && ones != 1) m_err[m] = 1;
         sum_cur = 0;
         for (int n = 0; n < 3; n++) begin
            nxt[n] = m_cr[m][n];
            sum_cur += m_cr[m][n];
         end
         if (valid) begin
            k = 0;
            for (int n = 0; n < 3; n++) if (grant[n]) k = n;
            if (nxt[k] > 0) nxt[k] -= 1;
            else m_err[m] = 1;
         end
         sum_nxt = nxt[0] + nxt[1] + nxt[2];
         if (m == 0) begin
            done = valid && (sum_nxt == 0);
         end else begin
            left = 0;
            for (int n = 0; n < 3; n++) if (req[n] && nxt[n] > 0) left = 1;
            done = !left && (m_seen[m] || valid);
         end
         if (done) begin
            for (int n = 0; n < 3; n++) m_cr[m][n] = weight_of(req_weight, n);
            m_seen[m] = 0;
            m_comp[m] = 1;
            m_cnt[m]  = (m_cnt[m] + 1) % m_mod[m];
         end else if (sum_cur == 0 && !m_seen[m]) begin
            for (int n = 0; n < 3; n++) m_cr[m][n] = weight_of(req_weight, n);
         end else begin
            for (int n = 0; n < 3; n++) m_cr[m][n] = nxt[n];
            if (valid) m_seen[m] = 1;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("s_credit", 32'(credit_s), 32'(pack_cr(0)));
      check("s_elig",   32'(elig_s),   32'(model_elig(0)));
      check("s_comp",   32'(comp_s),   32'(m_comp[0]));
      check("s_cnt",    32'(cnt_s),    32'(m_cnt[0]));
      check("s_err",    32'(err_s),    32'(m_err[0]));
      check("w_credit", 32'(credit_w), 32'(pack_cr(1)));
      check("w_elig",   32'(elig_w),   32'(model_elig(1)));
      check("w_comp",   32'(comp_w),   32'(m_comp[1]));
      check("w_cnt",    32'(cnt_w),    32'(m_cnt[1]));
      check("w_err",    32'(err_w),    32'(m_err[1]));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic do_grant(input int n);
      gv    = 1'b1;
      grant = 3'(1 << n);
      cycle();
      gv    = 1'b0;
      grant = '0;
   endtask

   task automatic do_reset();
      gv    = 1'b0;
      grant = '0;
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
   endtask

   typedef struct {
      logic       rst;
      logic [5:0] w;
      logic [2:0] rq;
      logic       v;
      logic [2:0] g;
      logic [5:0] e_cr;
      logic [2:0] e_el;
      logic       e_comp;
      logic [1:0] e_cnt;
      logic       e_err;
   } vec_t;

   vec_t tbl [19];
   int   pulses;

   initial begin
      // Directed STRICT vectors; weights {2,1,3} pack to 6'h36
      tbl[0]  = '{1'b0, 6'h36, 3'b111, 1'b0, 3'b000, 6'h00, 3'b000, 1'b0, 2'd0, 1'b0};
      tbl[1]  = '{1'b0, 6'h36, 3'b111, 1'b0, 3'b000, 6'h00, 3'b000, 1'b0, 2'd0, 1'b0};
      tbl[2]  = '{1'b1, 6'h36, 3'b111, 1'b0, 3'b000, 6'h36, 3'b111, 1'b0, 2'd0, 1'b0};
      tbl[3]  = '{1'b1, 6'h36, 3'b111, 1'b1, 3'b001, 6'h35, 3'b111, 1'b0, 2'd0, 1'b0};
      tbl[4]  = '{1'b1, 6'h36, 3'b111, 1'b1, 3'b010, 6'h31, 3'b101, 1'b0, 2'd0, 1'b0};
      tbl[5]  = '{1'b1, 6'h36, 3'b111, 1'b1, 3'b001, 6'h30, 3'b100, 1'b0, 2'd0, 1'b0};
      tbl[6]  = '{1'b1, 6'h36, 3'b111, 1'b1, 3'b100, 6'h20, 3'b100, 1'b0, 2'd0, 1'b0};
      tbl[7]  = '{1'b1, 6'h36, 3'b111, 1'b1, 3'b100, 6'h10, 3'b100, 1'b0, 2'd0, 1'b0};
      tbl[8]  = '{1'b1, 6'h36, 3'b111, 1'b1, 3'b100, 6'h36, 3'b111, 1'b1, 2'd1, 1'b0};
      tbl[9]  = '{1'b1, 6'h36, 3'b111, 1'b0, 3'b000, 6'h36, 3'b111, 1'b0, 2'd1, 1'b0};
      tbl[10] = '{1'b1, 6'h36, 3'b111, 1'b1, 3'b010, 6'h32, 3'b101, 1'b0, 2'd1, 1'b0};
      tbl[11] = '{1'b1, 6'h36, 3'b111, 1'b1, 3'b010, 6'h32, 3'b101, 1'b0, 2'd1, 1'b1};
      tbl[12] = '{1'b1, 6'h36, 3'b111, 1'b1, 3'b011, 6'h32, 3'b101, 1'b0, 2'd1, 1'b1};
      tbl[13] = '{1'b1, 6'h36, 3'b111, 1'b0, 3'b000, 6'h32, 3'b101, 1'b0, 2'd1, 1'b1};
      tbl[14] = '{1'b0, 6'h36, 3'b111, 1'b0, 3'b000, 6'h00, 3'b000, 1'b0, 2'd0, 1'b0};
      tbl[15] = '{1'b1, 6'h36, 3'b111, 1'b0, 3'b000, 6'h36, 3'b111, 1'b0, 2'd0, 1'b0};
      tbl[16] = '{1'b0, 6'h36, 3'b111, 1'b0, 3'b000, 6'h00, 3'b000, 1'b0, 2'd0, 1'b0};
      tbl[17] = '{1'b1, 6'h36, 3'b111, 1'b1, 3'b001, 6'h36, 3'b111, 1'b0, 2'd0, 1'b1};
      tbl[18] = '{1'b0, 6'h36, 3'b111, 1'b0, 3'b000, 6'h00, 3'b000, 1'b0, 2'd0, 1'b0};

      rst_n      = 1'b0;
      req_weight = 6'h36;
      req        = 3'b111;
      gv         = 1'b0;
      grant      = '0;

      for (int i = 0; i < 19; i++) begin
         rst_n      = tbl[i].rst;
         req_weight = tbl[i].w;
         req        = tbl[i].rq;
         gv         = tbl[i].v;
         grant      = tbl[i].g;
         cycle();
         check($sformatf("vec%0d_credit", i), 32'(credit_s), 32'(tbl[i].e_cr));
         check($sformatf("vec%0d_elig", i),   32'(elig_s),   32'(tbl[i].e_el));
         check($sformatf("vec%0d_comp", i),   32'(comp_s),   32'(tbl[i].e_comp));
         check($sformatf("vec%0d_cnt", i),    32'(cnt_s),    32'(tbl[i].e_cnt));
         check($sformatf("vec%0d_err", i),    32'(err_s),    32'(tbl[i].e_err));
      end
      gv    = 1'b0;
      grant = '0;

      // Mid-round weight change: old credits persist until the reload
      req_weight = 6'h36;
      req        = 3'b111;
      do_reset();
      do_grant(0);
      req_weight = 6'h15;
      cycle();
      check("mid_keep_credit", 32'(credit_s), 32'h35);
      do_grant(1);
      do_grant(0);
      do_grant(2);
      do_grant(2);
      check("mid_no_comp_yet", 32'(comp_s), 32'h0);
      do_grant(2);
      check("mid_comp", 32'(comp_s), 32'h1);
      check("mid_new_credit", 32'(credit_s), 32'h15);
      cycle();
      check("mid_next_round", 32'(credit_s), 32'h15);
      check("mid_comp_one_cycle", 32'(comp_s), 32'h0);

      // WORK_CONSERVING early completion with req2 idle
      req_weight = 6'h36;
      req        = 3'b011;
      do_reset();
      do_grant(0);
      do_grant(1);
      check("wc_no_comp_early", 32'(comp_w), 32'h0);
      do_grant(0);
      check("wc_comp", 32'(comp_w), 32'h1);
      check("wc_cnt", 32'(cnt_w), 32'h1);
      check("wc_reload", 32'(credit_w), 32'h36);
      check("strict_not_done", 32'(comp_s), 32'h0);
      check("strict_credit", 32'(credit_s), 32'h30);

      // Round counter wrap: five rounds on a 2-bit counter
      req_weight = 6'h15;
      req        = 3'b111;
      do_reset();
      for (int r = 0; r < 5; r++) begin
         for (int n = 0; n < 3; n++) do_grant(n);
      end
      check("wrap_cnt_s", 32'(cnt_s), 32'h1);
      check("wrap_cnt_w", 32'(cnt_w), 32'h5);

      // All-zero weights: no pulses, then recovery once a weight appears
      req_weight = 6'h00;
      req        = 3'b000;
      do_reset();
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         cycle();
         if (comp_s || comp_w) pulses++;
      end
      check("zero_pulses", 32'(pulses), 32'h0);
      check("zero_elig_s", 32'(elig_s), 32'h0);
      check("zero_elig_w", 32'(elig_w), 32'h0);
      req_weight = 6'h08;
      cycle();
      check("recover_elig_s", 32'(elig_s), 32'h2);
      check("recover_elig_w", 32'(elig_w), 32'h2);

      // Randomized traffic against the model
      req_weight = 6'h36;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 39) == 0) req_weight = 6'($urandom);
         req = 3'($urandom);
         gv  = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) grant = 3'($urandom);
         else grant = 3'(1 << $urandom_range(0, 2));
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
